// File: rtl/rvfi_trace_pipe_if.sv
// Trace sink port of the RVFI trace pipeline: one retired-instruction record per
// valid/ready handshake.
interface rvfi_trace_pipe_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ORDER_W = 64
);
  logic                valid;
  logic                ready;
  logic [ORDER_W-1:0]  order;
  logic [XLEN-1:0]     insn;
  logic [XLEN-1:0]     pc_rdata;
  logic [XLEN-1:0]     pc_wdata;
  logic [REG_AW-1:0]   rs1_addr;
  logic [REG_AW-1:0]   rs2_addr;
  logic [XLEN-1:0]     rs1_rdata;
  logic [XLEN-1:0]     rs2_rdata;
  logic [XLEN-1:0]     mem_addr;
  logic [XLEN/8-1:0]   mem_rmask;
  logic [XLEN/8-1:0]   mem_wmask;
  logic [XLEN-1:0]     mem_rdata;
  logic [XLEN-1:0]     mem_wdata;
  logic [REG_AW-1:0]   rd_addr;
  logic [XLEN-1:0]     rd_wdata;

  modport master (
    output valid, order, insn, pc_rdata, pc_wdata, rs1_addr, rs2_addr, rs1_rdata, rs2_rdata,
           mem_addr, mem_rmask, mem_wmask, mem_rdata, mem_wdata, rd_addr, rd_wdata,
    input  ready
  );

  modport slave (
    input  valid, order, insn, pc_rdata, pc_wdata, rs1_addr, rs2_addr, rs1_rdata, rs2_rdata,
           mem_addr, mem_rmask, mem_wmask, mem_rdata, mem_wdata, rd_addr, rd_wdata,
    output ready
  );
endinterface

// File: rtl/rvfi_trace_pipe.sv
// RVFI trace pipeline: captures a record at ID, merges EX/MEM/WB fields as it follows the
// core pipeline, stamps retire order and queues retired records for a valid/ready sink.
module rvfi_trace_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned EX_IDX     = 1,
  parameter int unsigned MEM_IDX    = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ORDER_W    = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stall,
  input  logic [PIPE_DEPTH-1:0] i_flush,
  input  logic                  i_id_valid,
  input  logic [XLEN-1:0]       i_id_insn,
  input  logic [XLEN-1:0]       i_id_pc_rdata,
  input  logic [XLEN-1:0]       i_id_pc_wdata,
  input  logic [REG_AW-1:0]     i_id_rs1_addr,
  input  logic [REG_AW-1:0]     i_id_rs2_addr,
  input  logic [XLEN-1:0]       i_ex_rs1_rdata,
  input  logic [XLEN-1:0]       i_ex_rs2_rdata,
  input  logic [XLEN-1:0]       i_mem_addr,
  input  logic [XLEN/8-1:0]     i_mem_rmask,
  input  logic [XLEN/8-1:0]     i_mem_wmask,
  input  logic [XLEN-1:0]       i_mem_rdata,
  input  logic [XLEN-1:0]       i_mem_wdata,
  input  logic [REG_AW-1:0]     i_wb_rd_addr,
  input  logic [XLEN-1:0]       i_wb_rd_wdata,
  rvfi_trace_pipe_if.master     o_trace,
  output logic                  o_overflow,
  output logic [15:0]           o_drop_cnt
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]   insn;
    logic [XLEN-1:0]   pc_rdata;
    logic [XLEN-1:0]   pc_wdata;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_rdata;
    logic [XLEN-1:0]   rs2_rdata;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN/8-1:0] mem_rmask;
    logic [XLEN/8-1:0] mem_wmask;
    logic [XLEN-1:0]   mem_rdata;
    logic [XLEN-1:0]   mem_wdata;
  } stage_t;

  typedef struct packed {
    stage_t             st;
    logic [REG_AW-1:0]  rd_addr;
    logic [XLEN-1:0]    rd_wdata;
    logic [ORDER_W-1:0] order;
  } rec_t;

  // Pipeline stages
  stage_t                r_stage [PIPE_DEPTH];
  stage_t                w_stage_d [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] r_vld;
  logic [PIPE_DEPTH-1:0] w_vld_d;
  stage_t                w_id_rec;

  // Retire and queue
  rec_t                  r_fifo [FIFO_DEPTH];
  logic [PtrW-1:0]       r_wptr;
  logic [PtrW-1:0]       r_rptr;
  logic [PtrW:0]         r_count;
  logic [ORDER_W-1:0]    r_order;
  logic                  r_overflow;
  logic [15:0]           r_drop_cnt;

  rec_t                  w_ret_rec;
  rec_t                  w_head;
  logic                  w_retire;
  logic                  w_not_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;

  always_comb begin
    w_id_rec          = '0;
    w_id_rec.insn     = i_id_insn;
    w_id_rec.pc_rdata = i_id_pc_rdata;
    w_id_rec.pc_wdata = i_id_pc_wdata;
    w_id_rec.rs1_addr = i_id_rs1_addr;
    w_id_rec.rs2_addr = i_id_rs2_addr;
  end

  // Flush applies whether or not the pipeline advances.
  always_comb begin
    for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
      w_stage_d[i] = r_stage[i];
      w_vld_d[i]   = r_vld[i] & ~i_flush[i];
    end
    if (!i_stall) begin
      w_stage_d[0] = w_id_rec;
      w_vld_d[0]   = i_id_valid & ~i_flush[0];
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
        w_stage_d[i] = r_stage[i-1];
        w_vld_d[i]   = r_vld[i-1] & ~i_flush[i];
        if (i == EX_IDX) begin
          w_stage_d[i].rs1_rdata = i_ex_rs1_rdata;
          w_stage_d[i].rs2_rdata = i_ex_rs2_rdata;
        end
        if (i == MEM_IDX) begin
          w_stage_d[i].mem_addr  = i_mem_addr;
          w_stage_d[i].mem_rmask = i_mem_rmask;
          w_stage_d[i].mem_wmask = i_mem_wmask;
          w_stage_d[i].mem_rdata = i_mem_rdata;
          w_stage_d[i].mem_wdata = i_mem_wdata;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_vld <= w_vld_d;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        r_stage[i] <= w_stage_d[i];
      end
    end
  end

  assign w_retire    = ~i_stall & r_vld[PIPE_DEPTH-1];
  assign w_not_empty = (r_count != '0);
  assign w_full      = (r_count == FullCnt);
  assign w_pop       = w_not_empty & o_trace.ready;
  // A full queue still accepts a retire when the head leaves in the same cycle.
  assign w_push      = w_retire & (~w_full | w_pop);
  assign w_drop      = w_retire & w_full & ~w_pop;

  always_comb begin
    w_ret_rec          = '0;
    w_ret_rec.st       = r_stage[PIPE_DEPTH-1];
    w_ret_rec.rd_addr  = i_wb_rd_addr;
    w_ret_rec.rd_wdata = (i_wb_rd_addr == '0) ? '0 : i_wb_rd_wdata;
    w_ret_rec.order    = r_order;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_order    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_ret_rec;
        r_wptr         <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PtrW + 1)'(1);
        2'b01:   r_count <= r_count - (PtrW + 1)'(1);
        default: r_count <= r_count;
      endcase
      // Dropped records still consume an order number so the sink can see the gap.
      if (w_retire) begin
        r_order <= r_order + ORDER_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end
  end

  assign w_head = w_not_empty ? r_fifo[r_rptr] : '0;

  assign o_trace.valid     = w_not_empty;
  assign o_trace.order     = w_head.order;
  assign o_trace.insn      = w_head.st.insn;
  assign o_trace.pc_rdata  = w_head.st.pc_rdata;
  assign o_trace.pc_wdata  = w_head.st.pc_wdata;
  assign o_trace.rs1_addr  = w_head.st.rs1_addr;
  assign o_trace.rs2_addr  = w_head.st.rs2_addr;
  assign o_trace.rs1_rdata = w_head.st.rs1_rdata;
  assign o_trace.rs2_rdata = w_head.st.rs2_rdata;
  assign o_trace.mem_addr  = w_head.st.mem_addr;
  assign o_trace.mem_rmask = w_head.st.mem_rmask;
  assign o_trace.mem_wmask = w_head.st.mem_wmask;
  assign o_trace.mem_rdata = w_head.st.mem_rdata;
  assign o_trace.mem_wdata = w_head.st.mem_wdata;
  assign o_trace.rd_addr   = w_head.rd_addr;
  assign o_trace.rd_wdata  = w_head.rd_wdata;

  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;

endmodule
